// File: rtl/output_pkg.sv
// Shared constants and helpers for the handshaked output stage.
// Holds the default geometry and the width of the occupancy counter.
package output_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 4;

  // One extra bit so the counter can represent a completely full buffer.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/output_buffer_mem.sv
// DEPTH x WIDTH storage array for the output buffer.
// Has one synchronous write port and one asynchronous read port; contents are never reset.
module output_buffer_mem
  import output_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/output_buffer.sv
// Handshaked show-ahead output FIFO between the core datapath and the output pins.
// Owns the pointers, occupancy count, sticky overflow flag and the held last word.
module output_buffer
  import output_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter bit HOLD_LAST = 1'b1
) (
  input  logic                          clk,
  input  logic                          GlobalReset,
  input  logic [WIDTH-1:0]              data_in,
  input  logic                          srdyo,
  output logic                          in_ready,
  input  logic                          flush,
  output logic [WIDTH-1:0]              data_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             overflow_q;
  logic [WIDTH-1:0] last_q;
  logic [WIDTH-1:0] head_word;
  logic             push;
  logic             pop;

  assign in_ready  = (count_q != FULL_COUNT);
  assign out_valid = (count_q != '0);
  assign push      = srdyo & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign count     = count_q;
  assign overflow  = overflow_q;

  output_buffer_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (data_in),
    .rd_addr (rd_ptr),
    .rd_data (head_word)
  );

  // Flush clears occupancy and the overflow flag but deliberately keeps last_q.
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      last_q     <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        last_q <= head_word;
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
      if (srdyo && !in_ready) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_comb begin
    data_out = '0;
    if (out_valid) begin
      data_out = head_word;
    end else if (HOLD_LAST) begin
      data_out = last_q;
    end
  end

endmodule

// File: tb/tb_output_buffer.sv
// Scoreboard bench for output_buffer: a queue-based reference model drives expectations,
// a negedge monitor checks every delivered word; a HOLD_LAST=0 twin checks the empty-word path.
module tb_output_buffer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             GlobalReset;
  logic [WIDTH-1:0] data_in;
  logic             srdyo;
  logic             flush;
  logic             out_ready;

  logic             in_ready,  in_ready_z;
  logic [WIDTH-1:0] data_out,  data_out_z;
  logic             out_valid, out_valid_z;
  logic [CW-1:0]    count,     count_z;
  logic             overflow,  overflow_z;

  output_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HOLD_LAST(1'b1)) dut (
    .clk         (clk),
    .GlobalReset (GlobalReset),
    .data_in     (data_in),
    .srdyo       (srdyo),
    .in_ready    (in_ready),
    .flush       (flush),
    .data_out    (data_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .count       (count),
    .overflow    (overflow)
  );

  output_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HOLD_LAST(1'b0)) dut_z (
    .clk         (clk),
    .GlobalReset (GlobalReset),
    .data_in     (data_in),
    .srdyo       (srdyo),
    .in_ready    (in_ready_z),
    .flush       (flush),
    .data_out    (data_out_z),
    .out_valid   (out_valid_z),
    .out_ready   (out_ready),
    .count       (count_z),
    .overflow    (overflow_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int num_checks = 0;
  int num_fails  = 0;

  // Reference model: buffer contents, sticky flag and last delivered word.
  logic [WIDTH-1:0] model_q [$];
  logic [WIDTH-1:0] exp_q   [$];
  bit               model_ovf  = 1'b0;
  logic [WIDTH-1:0] model_last = '0;

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string phase);
    int sz;
    sz = model_q.size();
    checkEq({phase, ".count"},     32'(count),     32'(sz));
    checkEq({phase, ".out_valid"}, 32'(out_valid), 32'(sz != 0));
    checkEq({phase, ".in_ready"},  32'(in_ready),  32'(sz != DEPTH));
    checkEq({phase, ".overflow"},  32'(overflow),  32'(model_ovf));
    checkEq({phase, ".overflow_z"}, 32'(overflow_z), 32'(model_ovf));
    if (sz != 0) begin
      checkEq({phase, ".head"},   data_out,   model_q[0]);
      checkEq({phase, ".head_z"}, data_out_z, model_q[0]);
    end else begin
      checkEq({phase, ".held"},   data_out,   model_last);
      checkEq({phase, ".zero_z"}, data_out_z, 32'h0);
    end
  endtask

  // Drive one cycle of inputs, advance the model to the state after the next edge, then check.
  task automatic applyStimulus(input bit s, input logic [WIDTH-1:0] d, input bit r, input bit f,
                               input string phase);
    bit acc, take;
    srdyo     = s;
    data_in   = d;
    out_ready = r;
    flush     = f;
    take = (model_q.size() != 0) && r;
    acc  = s && (model_q.size() < DEPTH);
    if (f) begin
      model_q.delete();
      exp_q.delete();
      model_ovf = 1'b0;
    end else begin
      if (s && model_q.size() == DEPTH) model_ovf = 1'b1;
      if (take) model_last = model_q.pop_front();
      if (acc) begin
        model_q.push_back(d);
        exp_q.push_back(d);
      end
    end
    @(posedge clk);
    #1;
    checkOutput(phase);
  endtask

  task automatic drain(input string phase);
    for (int i = 0; i < DEPTH + 2 && model_q.size() != 0; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, phase);
    end
    checkEq({phase, ".scoreboard_empty"}, 32'(exp_q.size()), 32'h0);
  endtask

  // Monitor: a transfer happens at the coming edge when valid and ready are both high.
  always @(negedge clk) begin
    if (!GlobalReset && out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) begin
        num_checks++;
        num_fails++;
        $display("[TB] FAIL unexpected_output: got 0x%h, expected no word at %0t", data_out, $time);
      end else begin
        checkEq("delivered_word", data_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    GlobalReset = 1'b1;
    srdyo       = 1'b0;
    data_in     = '0;
    out_ready   = 1'b0;
    flush       = 1'b0;
    #12 GlobalReset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_reset");

    $display("[TB] asynchronous reset with two words stored");
    applyStimulus(1'b1, 32'h000000A1, 1'b0, 1'b0, "reset_fill");
    applyStimulus(1'b1, 32'h000000A2, 1'b0, 1'b0, "reset_fill");
    #2;
    srdyo = 1'b0;
    GlobalReset = 1'b1;
    #1;
    checkEq("reset.count",     32'(count),     32'h0);
    checkEq("reset.out_valid", 32'(out_valid), 32'h0);
    checkEq("reset.in_ready",  32'(in_ready),  32'h1);
    checkEq("reset.data_out",  data_out,       32'h0);
    model_q.delete();
    exp_q.delete();
    model_ovf  = 1'b0;
    model_last = '0;
    #3 GlobalReset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_release");

    $display("[TB] ordered fill and drain");
    applyStimulus(1'b1, 32'h11111111, 1'b0, 1'b0, "fill");
    applyStimulus(1'b1, 32'h22222222, 1'b0, 1'b0, "fill");
    applyStimulus(1'b1, 32'h33333333, 1'b0, 1'b0, "fill");
    applyStimulus(1'b1, 32'h44444444, 1'b0, 1'b0, "fill");
    checkEq("fill.count_full", 32'(count), 32'd4);
    drain("fill_drain");

    $display("[TB] overflow while full with simultaneous pop");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 32'h0000C000 + 32'(i), 1'b0, 1'b0, "ovf_fill");
    end
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, "ovf_hit");
    checkEq("ovf.count_after", 32'(count), 32'd3);
    checkEq("ovf.flag_after",  32'(overflow), 32'h1);
    drain("ovf_drain");

    $display("[TB] wrap-around with simultaneous push and pop");
    applyStimulus(1'b1, 32'h000000B1, 1'b0, 1'b0, "wrap_prime");
    applyStimulus(1'b1, 32'h000000B2, 1'b0, 1'b0, "wrap_prime");
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b1, 32'(i), 1'b1, 1'b0, "wrap");
    end
    drain("wrap_drain");

    $display("[TB] hold-last on empty");
    applyStimulus(1'b1, 32'h0000ABCD, 1'b0, 1'b0, "hold_push");
    applyStimulus(1'b0, '0, 1'b1, 1'b0, "hold_pop");
    checkEq("hold.data_out",   data_out,   32'h0000ABCD);
    checkEq("hold.data_out_z", data_out_z, 32'h0);

    $display("[TB] flush priority over push, pop and overflow");
    applyStimulus(1'b1, 32'h000000C1, 1'b0, 1'b0, "flush_prime");
    applyStimulus(1'b1, 32'h000000C2, 1'b0, 1'b0, "flush_prime");
    applyStimulus(1'b1, 32'h00000005, 1'b1, 1'b1, "flush");
    checkEq("flush.count",    32'(count),    32'h0);
    checkEq("flush.overflow", 32'(overflow), 32'h0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, "flush_idle");

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 31) == 0), "random");
    end
    drain("random_drain");
    applyStimulus(1'b0, '0, 1'b0, 1'b0, "final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
